// File: rtl/instruction_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage_pkg
// Description : Opcodes, instruction field positions and fetch FSM encoding
//               shared by the fetch stage and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_stage_pkg;

    localparam logic [5:0] OP_RFORMAT = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b000001;
    localparam logic [5:0] OP_SW      = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int PC_STEP    = 4;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH    = 2'd0;
    localparam fetch_state_t HOLD     = 2'd1;
    localparam fetch_state_t REDIRECT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage_if
// Description : Instruction-memory request/ready bus between fetch and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imemReq;
    logic [ADDR_W-1:0]  imemAddr;
    logic               imemReady;
    logic [INSTR_W-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_stage_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : Pipeline register holding valid, instruction and pc+4, with
//               load / hold / flush / bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_load,
    input  wire logic               i_flush,
    input  wire logic               i_bubble,
    input  wire logic [INSTR_W-1:0] i_instruction,
    input  wire logic [ADDR_W-1:0]  i_pcPlus4,
    output logic                    o_valid,
    output logic [INSTR_W-1:0]      o_instruction,
    output logic [ADDR_W-1:0]       o_pcPlus4
);

    // Flush clears the instruction too; a bubble only drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid       <= 1'b0;
            o_instruction <= '0;
            o_pcPlus4     <= '0;
        end else if (i_flush) begin
            o_valid       <= 1'b0;
            o_instruction <= '0;
        end else if (i_load) begin
            o_valid       <= 1'b1;
            o_instruction <= i_instruction;
            o_pcPlus4     <= i_pcPlus4;
        end else if (i_bubble) begin
            o_valid       <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : PC, fetch FSM with one-entry skid buffer and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               INSTR_W  = 32
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                stall,
    input  wire logic                branchTaken,
    input  wire logic [ADDR_W-1:0]   branchTarget,
    instruction_fetch_stage_if.master imem,
    output logic                     ifIdValid,
    output logic [INSTR_W-1:0]       ifIdInstruction,
    output logic [ADDR_W-1:0]        ifIdPcPlus4,
    output logic [5:0]               opCode,
    output logic [ADDR_W-1:0]        pc
);

    fetch_state_t       r_state;
    fetch_state_t       w_stateNext;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pcNext;
    logic [ADDR_W-1:0]  w_pcPlus4;
    logic [INSTR_W-1:0] r_skidData;
    logic [ADDR_W-1:0]  r_skidPcPlus4;
    logic               w_skidCapture;
    logic               w_skidClear;
    logic               w_load;
    logic               w_flush;
    logic               w_bubble;
    logic [INSTR_W-1:0] w_loadInstr;
    logic [ADDR_W-1:0]  w_loadPcPlus4;

    assign w_pcPlus4 = r_pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

    // A taken branch outranks stall and imemReady in every state.
    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_skidCapture = 1'b0;
        w_skidClear   = 1'b0;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_loadInstr   = imem.imemData;
        w_loadPcPlus4 = w_pcPlus4;
        if (branchTaken) begin
            w_pcNext    = branchTarget & ~ADDR_W'(3);
            w_flush     = 1'b1;
            w_skidClear = 1'b1;
            w_stateNext = REDIRECT;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imemReady && !stall) begin
                        w_load   = 1'b1;
                        w_pcNext = w_pcPlus4;
                    end else if (imem.imemReady) begin
                        w_skidCapture = 1'b1;
                        w_stateNext   = HOLD;
                    end else if (!stall) begin
                        w_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_load        = 1'b1;
                        w_loadInstr   = r_skidData;
                        w_loadPcPlus4 = r_skidPcPlus4;
                        w_pcNext      = w_pcPlus4;
                        w_skidClear   = 1'b1;
                        w_stateNext   = FETCH;
                    end
                end
                REDIRECT: begin
                    w_bubble    = 1'b1;
                    w_stateNext = FETCH;
                end
                default: begin
                    w_stateNext = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_skidClear) begin
            r_skidData    <= '0;
            r_skidPcPlus4 <= '0;
        end else if (w_skidCapture) begin
            r_skidData    <= imem.imemData;
            r_skidPcPlus4 <= w_pcPlus4;
        end
    end

    if_id_register #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_register (
        .clk           (clk),
        .rst           (reset),
        .i_load        (w_load),
        .i_flush       (w_flush),
        .i_bubble      (w_bubble),
        .i_instruction (w_loadInstr),
        .i_pcPlus4     (w_loadPcPlus4),
        .o_valid       (ifIdValid),
        .o_instruction (ifIdInstruction),
        .o_pcPlus4     (ifIdPcPlus4)
    );

    assign imem.imemReq  = (r_state == FETCH) && !reset;
    assign imem.imemAddr = r_pc;
    assign pc            = r_pc;
    assign opCode        = ifIdInstruction[OPCODE_MSB:OPCODE_LSB];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Cycle table plus wrap/reset sequences for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        expReq;
        logic [15:0] expAddr;
        logic [15:0] expPc;
        logic        expValid;
        logic [31:0] expInstr;
        logic [15:0] expPp4;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [15:0] pp4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        stall, branchTaken;
    logic [15:0] branchTarget;
    logic        ifIdValid, ifIdValid2;
    logic [31:0] ifIdInstruction, ifIdInstruction2;
    logic [15:0] ifIdPcPlus4, ifIdPcPlus42, pc, pc2;
    logic [5:0]  opCode, opCode2;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    vec_t vecs[20];

    instruction_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus  ();
    instruction_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus2 ();

    instruction_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .imem(bus.master), .ifIdValid(ifIdValid),
        .ifIdInstruction(ifIdInstruction), .ifIdPcPlus4(ifIdPcPlus4), .opCode(opCode), .pc(pc)
    );

    instruction_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(16'hFFFC), .INSTR_W(INSTR_W)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0), .branchTaken(1'b0),
        .branchTarget(16'h0000), .imem(bus2.master), .ifIdValid(ifIdValid2),
        .ifIdInstruction(ifIdInstruction2), .ifIdPcPlus4(ifIdPcPlus42), .opCode(opCode2), .pc(pc2)
    );

    always #5 clk = ~clk;

    // Memory contents: word k (k = addr/4 + 1) holds opcode k and payload k*16.
    function automatic logic [31:0] memword(input logic [15:0] a);
        logic [31:0] k;
        k = 32'(a >> 2) + 32'd1;
        return (k << 26) | (k << 4);
    endfunction

    always_comb bus.imemData  = memword(bus.imemAddr);
    always_comb bus2.imemData = memword(bus2.imemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic s, input logic b,
                                input logic [15:0] t, input logic rq, input logic [15:0] ad,
                                input logic [15:0] p, input logic v, input logic [31:0] ins,
                                input logic [15:0] pp);
        vec_t x;
        x.rst = r; x.ready = rdy; x.stall = s; x.br = b; x.tgt = t;
        x.expReq = rq; x.expAddr = ad; x.expPc = p; x.expValid = v;
        x.expInstr = ins; x.expPp4 = pp;
        return x;
    endfunction

    initial begin
        exp_t e;
        //            rst rdy stl br  tgt       req addr      pc        v   instr          pp4
        vecs[0]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0004, 1, 32'h04000010, 16'h0004);
        vecs[1]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0008, 1, 32'h08000020, 16'h0008);
        vecs[2]  = mk(0, 1, 1, 0, 16'h0000, 1, 16'h0008, 16'h0008, 1, 32'h08000020, 16'h0008);
        vecs[3]  = mk(0, 1, 1, 0, 16'h0000, 0, 16'h0008, 16'h0008, 1, 32'h08000020, 16'h0008);
        vecs[4]  = mk(0, 1, 1, 0, 16'h0000, 0, 16'h0008, 16'h0008, 1, 32'h08000020, 16'h0008);
        vecs[5]  = mk(0, 1, 0, 0, 16'h0000, 0, 16'h0008, 16'h000C, 1, 32'h0C000030, 16'h000C);
        vecs[6]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h000C, 16'h000C, 0, 32'h0C000030, 16'h000C);
        vecs[7]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h000C, 16'h000C, 0, 32'h0C000030, 16'h000C);
        vecs[8]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'h000C, 16'h0010, 1, 32'h10000040, 16'h0010);
        vecs[9]  = mk(0, 1, 0, 1, 16'h0042, 1, 16'h0010, 16'h0040, 0, 32'h00000000, 16'h0010);
        vecs[10] = mk(0, 1, 0, 0, 16'h0000, 0, 16'h0040, 16'h0040, 0, 32'h00000000, 16'h0010);
        vecs[11] = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0040, 16'h0044, 1, 32'h44000110, 16'h0044);
        vecs[12] = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0044, 16'h0044, 1, 32'h44000110, 16'h0044);
        vecs[13] = mk(0, 1, 1, 0, 16'h0000, 1, 16'h0044, 16'h0044, 1, 32'h44000110, 16'h0044);
        vecs[14] = mk(0, 1, 1, 1, 16'h0080, 0, 16'h0044, 16'h0080, 0, 32'h00000000, 16'h0044);
        vecs[15] = mk(0, 1, 0, 0, 16'h0000, 0, 16'h0080, 16'h0080, 0, 32'h00000000, 16'h0044);
        vecs[16] = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0080, 16'h0084, 1, 32'h84000210, 16'h0084);
        vecs[17] = mk(0, 1, 1, 0, 16'h0000, 1, 16'h0084, 16'h0084, 1, 32'h84000210, 16'h0084);
        vecs[18] = mk(1, 1, 1, 0, 16'h0000, 0, 16'h0084, 16'h0000, 0, 32'h00000000, 16'h0000);
        vecs[19] = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0004, 1, 32'h04000010, 16'h0004);

        reset = 1'b1; reset2 = 1'b1; stall = 1'b0; branchTaken = 1'b0;
        branchTarget = '0; bus.imemReady = 1'b0; bus2.imemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("req_in_reset", 32'(bus.imemReq), 32'd0);
        reset = 1'b0;
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_valid", 32'(ifIdValid), 32'd0);
        check("rst_instr", ifIdInstruction, 32'h0);
        check("rst_pp4", 32'(ifIdPcPlus4), 32'h0);

        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst;
            bus.imemReady = vecs[i].ready;
            stall = vecs[i].stall;
            branchTaken = vecs[i].br;
            branchTarget = vecs[i].tgt;
            #1;
            check($sformatf("req[%0d]", i), 32'(bus.imemReq), 32'(vecs[i].expReq));
            check($sformatf("addr[%0d]", i), 32'(bus.imemAddr), 32'(vecs[i].expAddr));
            e.pc = vecs[i].expPc; e.valid = vecs[i].expValid;
            e.instr = vecs[i].expInstr; e.pp4 = vecs[i].expPp4;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("pc[%0d]", i), 32'(pc), 32'(e.pc));
            check($sformatf("valid[%0d]", i), 32'(ifIdValid), 32'(e.valid));
            check($sformatf("instr[%0d]", i), ifIdInstruction, e.instr);
            check($sformatf("pp4[%0d]", i), 32'(ifIdPcPlus4), 32'(e.pp4));
            check($sformatf("opcode[%0d]", i), 32'(opCode), 32'(e.instr[31:26]));
        end
        reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; bus.imemReady = 1'b0;

        // PC wrap from 0xFFFC on the second instance.
        check("wrap_rst_pc", 32'(pc2), 32'h0000FFFC);
        reset2 = 1'b0;
        bus2.imemReady = 1'b1;
        #1;
        check("wrap_addr", 32'(bus2.imemAddr), 32'h0000FFFC);
        @(posedge clk);
        #1;
        check("wrap_pc", 32'(pc2), 32'h0000);
        check("wrap_valid", 32'(ifIdValid2), 32'd1);
        check("wrap_instr", ifIdInstruction2, 32'h00040000);
        check("wrap_pp4", 32'(ifIdPcPlus42), 32'h0000);
        check("wrap_opcode", 32'(opCode2), 32'd0);
        @(posedge clk);
        #1;
        check("wrap_next_pc", 32'(pc2), 32'h0004);
        check("wrap_next_instr", ifIdInstruction2, 32'h04000010);
        check("wrap_next_opcode", 32'(opCode2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
